// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared state type and width helpers for the sequential multiplier
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_mul_state_t;

  // Full product width for a given operand width.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_sign_adj.sv
// rtl/seq_mul_sign_adj.sv - conditional two's-complement negate (magnitude / sign restore)
module seq_mul_sign_adj #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negating the most-negative value yields the same bit pattern, which read
  // as unsigned is exactly its magnitude, so no special case is needed.
  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - parametrised shift-add multiplier with start/busy/done handshake
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             signed_mode,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  output logic                             busy,
  output logic                             done,
  output logic [prod_width(WIDTH)-1:0]     product
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  seq_mul_state_t r_state;
  seq_mul_state_t w_next_state;
  logic           w_accept;
  logic           w_last;

  logic [CW-1:0]    r_cnt;
  logic [PW:0]      r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_neg;
  logic [PW-1:0]    r_product;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [PW:0]      w_acc_pre;
  logic [PW:0]      w_acc_next;
  logic [PW-1:0]    w_prod_final;

  seq_mul_sign_adj #(.W(WIDTH)) u_mag_a (
    .i_val (a),
    .i_neg (signed_mode & a[WIDTH-1]),
    .o_val (w_mag_a)
  );

  seq_mul_sign_adj #(.W(WIDTH)) u_mag_b (
    .i_val (b),
    .i_neg (signed_mode & b[WIDTH-1]),
    .o_val (w_mag_b)
  );

  // Upper half of the accumulator plus multiplicand; bit PW of r_acc is always
  // zero after a shift, so the sum never overflows WIDTH+1 bits.
  assign w_sum      = r_acc[PW:WIDTH] + {1'b0, r_a};
  assign w_acc_pre  = r_b[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;
  assign w_acc_next = w_acc_pre >> 1;
  assign w_last     = (r_state == RUN) && (r_cnt == CW'(1));

  seq_mul_sign_adj #(.W(PW)) u_neg_p (
    .i_val (w_acc_next[PW-1:0]),
    .i_neg (r_neg),
    .o_val (w_prod_final)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, request acceptance and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand latch on accept, one shift-add step per RUN cycle, product capture on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= w_mag_a;
      r_b   <= w_mag_b;
      r_neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_cnt <= CW'(WIDTH);
      r_acc <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_next;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_product <= w_prod_final;
      end
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_mul_param.sv
// tb/tb_seq_mul_param.sv - scoreboard bench for seq_mul_param
module tb_seq_mul_param;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sm;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [PW-1:0] product;

  logic       rst4, start4, sm4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [7:0] product4;

  seq_mul_param #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (sm),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  seq_mul_param #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst4),
    .start       (start4),
    .signed_mode (sm4),
    .a           (a4),
    .b           (b4),
    .busy        (busy4),
    .done        (done4),
    .product     (product4)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   model_left = 0;
  bit   exp_busy   = 1'b0;
  bit   exp_done   = 1'b0;
  bit   edge_rst   = 1'b1;
  logic [PW-1:0] exp_held = '0;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint vx, vy, p;
    vx = s ? longint'($signed(x)) : longint'(x);
    vy = s ? longint'($signed(y)) : longint'(y);
    p  = vx * vy;
    return PW'(p);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an operation is in flight for W edges after acceptance.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    edge_rst = rst;
    exp_done = 1'b0;
    if (rst) begin
      model_left = 0;
      sb.delete();
    end else if (start && model_left == 0) begin
      e.prod = ref_mul(a, b, sm);
      e.due  = cyc + W;
      sb.push_back(e);
      model_left = W;
    end else if (model_left > 0) begin
      model_left--;
      if (model_left == 0) exp_done = 1'b1;
    end
    exp_busy = (model_left > 0);
  end

  // Monitor: compares status every cycle and pops the scoreboard on each done.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (edge_rst) exp_held = '0;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done at cycle %0d: got done with empty scoreboard", cyc);
        end else begin
          e = sb.pop_front();
          check("product", product, e.prod);
          check("latency", cyc, e.due);
          exp_held = e.prod;
        end
      end
      check("product_held", product, exp_held);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x; b = y; sm = s; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
    repeat (W + 1) tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    rst4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) tick();

    // WIDTH=4 directed run while the wide instance sits in reset
    rst4 = 1'b0;
    tick();
    a4 = 4'd3; b4 = 4'd4; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 10) begin
      tick();
      lat++;
    end
    check("w4_latency", lat, 4);
    check("w4_product", product4, 8'd12);
    check("w4_busy_at_done", busy4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("w4_hold", product4, 8'd12);
    end

    rst = 1'b0;
    tick();

    op(8'd255, 8'd255, 1'b0);
    check("u255x255", product, 16'hFE01);
    op(8'd0, 8'd200, 1'b0);
    check("u0x200", product, 16'h0000);
    op(8'hFD, 8'd5, 1'b1);
    check("s_m3x5", product, 16'hFFF1);
    op(8'h80, 8'h80, 1'b1);
    check("s_m128xm128", product, 16'h4000);
    op(8'h80, 8'h7F, 1'b1);
    check("s_m128x127", product, 16'hC080);

    // second start during RUN is ignored
    a = 8'd2; b = 8'd3; sm = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    check("ignored_start", product, 16'd6);

    // start held high, operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 5 * (W + 1); i++) begin
      a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      tick();
    end
    start = 1'b0;
    repeat (W + 2) tick();

    // reset in the middle of RUN
    a = 8'd100; b = 8'd77; sm = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_product", product, 16'd0);
    op(8'd7, 8'd6, 1'b0);
    check("after_abort", product, 16'd42);

    // reset and start on the same edge
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", busy, 1'b0);
    repeat (2) tick();

    // random traffic including occasional resets
    for (int i = 0; i < 400; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      sm    = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 3) tick();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mul_param.md
# seq_mul_param

Parametrised sequential shift-add multiplier, the successor to the 4×4 Tiny Tapeout sequential multiplier. It adds:
- configurable operand width;
- per-operation signed/unsigned mode;
- an explicit start/busy/done handshake;
- a held product register.

It sits behind the top-level `tt_um_*` pin wrapper, which maps operands, mode and start onto `ui_in`/`uio_in` and the product onto `uo_out`/`uio_out`.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits, 2..16; product is 2·WIDTH bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled each edge; accepted only in IDLE or DONE.
- `signed_mode` in 1: 1 = two's-complement operands; 0 = unsigned; latched on accept.
- `a` in WIDTH: multiplicand; latched on accept.
- `b` in WIDTH: multiplier; latched on accept.
- `busy` out 1: high while iterating.
- `done` out 1: one-cycle pulse when `product` becomes valid.
- `product` out 2·WIDTH: result; held until the next accepted start or reset.

## Operation
- States (enum in package): IDLE, RUN, DONE.
- Reset values: state IDLE; `busy` 0, `done` 0, `product` 0; internal counter, accumulator and operand registers 0.
- IDLE:
  - `start`=1 → latch `a`, `b`, `signed_mode`; load counter with WIDTH; clear accumulator; go to RUN.
  - Otherwise remain in IDLE.
- Operand preparation on accept:
  - signed_mode=1: store magnitudes |a|, |b| as WIDTH-bit unsigned, and store neg = a[MSB] XOR b[MSB].
  - Most-negative operand: magnitude 2^(WIDTH-1) fits unsigned; no overflow special case.
  - signed_mode=0: store operands as-is; neg = 0.
- RUN, one iteration per cycle:
  - If multiplier LSB = 1, add multiplicand into the upper half of the 2·WIDTH+1-bit accumulator.
  - Shift accumulator right by one; shift multiplier right by one; decrement counter.
  - When the counter reaches 0 after the iteration: write `product` (two's-complement negate if neg=1), then go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 here is accepted as in IDLE (back-to-back); otherwise go to IDLE.
- `start` during RUN is ignored; it is not queued, and latched operands are unaffected.
- Changing `a`, `b` or `signed_mode` after accept has no effect on the running operation.
- Result is exact for all inputs. Full 2·WIDTH-bit product; no truncation or saturation.
- Reset mid-RUN: abort immediately, clear `product` to 0, no `done` pulse.
- `rst` and `start` high on the same edge: reset wins.

## Timing
- Accept edge E0 (start=1 in IDLE/DONE) → `busy`=1 from E0 through edge E(WIDTH).
- `product` valid and `done`=1 after edge E(WIDTH), i.e. WIDTH cycles after accept; `busy`=0 in the same cycle.
- Throughput: one operation per WIDTH+1 cycles when start is held high continuously; back-to-back accept on the DONE cycle gives exactly WIDTH+1 cycles between `done` pulses.
- `done` and `busy` are never high simultaneously.
- `product` changes only on the DONE-entry edge or on reset; it is stable in every other cycle.

## Structure
Shared package `seq_mul_pkg`:
- state enum `seq_mul_state_t` (IDLE, RUN, DONE);
- localparam functions for product width (2·WIDTH) and counter width ($clog2(WIDTH+1)).

Sub-module `seq_mul_sign_adj`:
- combinational magnitude/negate helper, parametrised on width;
- instantiated twice for operand magnitude and once for product negation.

Everything else (FSM, counter, shift-add datapath) lives in `seq_mul_param`.

## Test plan
- WIDTH=4, unsigned, a=3, b=4, 1-cycle start pulse → `done` exactly 4 cycles after accept; `product`=12; `product` holds 12 for the following 20 cycles.
- WIDTH=8, unsigned, a=255, b=255 → `product`=0xFE01. Same run with a=0, b=200 → 0x0000; `done` still arrives after 8 cycles.
- WIDTH=8, signed: a=-3 (0xFD), b=5 → 0xFFF1; a=-128, b=-128 → 0x4000; a=-128, b=127 → 0xC080.
- WIDTH=8: start with a=2, b=3; pulse start again at cycle 3 with a=9, b=9 → second request ignored; `product`=6; `busy` stays high continuously until `done`.
- Continuous start held high, operands changed on each DONE cycle → `done` pulses every 9 cycles; each product matches the operands latched at its own accept.
- WIDTH=8: `rst` asserted at cycle 4 of RUN → next cycle `busy`=0, `product`=0, no `done`. A subsequent start computes 7×6=42 correctly. `rst` and `start` high together → stays IDLE.
